mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single word-wide memory port among NUM_REQ requesters: matcher instances, the table-update writer and debug readback.
- Each requester drives a matcher-style memory interface (ce/we/addr/width/data, ready back) and holds ce high for a whole multi-word access sequence.
- Grants are round-robin and locked while the owner holds ce, so a key/value burst is never interleaved with another requester's accesses.
- Sits between the requesters and the memory controller.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MAX_HOLD, 0, maximum cycles one grant may be held before hold_err_o is set; 0 disables the check.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- req_ce_i  in  NUM_REQ  per-requester access enable; held high for a whole sequence.
- req_we_i  in  NUM_REQ  per-requester write enable.
- req_addr_i  in  NUM_REQ*ADDR_W  packed addresses; requester i in slice [i*ADDR_W +: ADDR_W].
- req_width_i  in  NUM_REQ*4  packed byte widths.
- req_data_i  in  NUM_REQ*DATA_W  packed write data.
- req_ready_o  out  NUM_REQ  per-requester ready; only the owner's bit can be 1.
- req_data_o  out  DATA_W  read data, broadcast to all requesters.
- mem_ce_o  out  1  memory enable.
- mem_we_o  out  1  memory write enable.
- mem_addr_o  out  ADDR_W  memory address.
- mem_width_o  out  4  memory access width in bytes.
- mem_data_o  out  DATA_W  memory write data.
- mem_data_i  in  DATA_W  memory read data.
- mem_ready_i  in  1  memory ready / access complete.
- grant_o  out  NUM_REQ  one-hot current owner; all zero when IDLE.
- hold_err_o  out  1  sticky hold-timeout flag.

Behaviour:
- States:
  - IDLE: no owner.
  - BUSY: registered owner index `owner`.
  - Registers: `last` (last owner index), hold_cnt, hold_err_o.
- Reset:
  - At the clock edge: state=IDLE, owner=0, last=NUM_REQ-1, hold_cnt=0, hold_err_o=0.
  - While rst is high: mem_ce_o=0, mem_we_o=0, mem_addr_o=0, mem_width_o=0, mem_data_o=0, req_ready_o=0, grant_o=0. These are combinationally gated, so a reset in mid-burst drops the port immediately.
  - req_data_o = mem_data_i at all times.
- Arbitration:
  - Search for the first i with req_ce_i[i]=1, in the order last+1, last+2, ... modulo NUM_REQ.
  - IDLE with any ce set: owner<=winner, state<=BUSY, hold_cnt<=0. Grant latency is one cycle: mem_ce_o rises on the cycle after ce is first seen.
  - IDLE with no ce set: stay in IDLE.
- BUSY outputs:
  - mem_* = the owner's fields while req_ce_i[owner]=1; mem_ce_o=mem_we_o=0 otherwise.
  - grant_o = one-hot(owner).
  - req_ready_o[owner] = mem_ready_i & req_ce_i[owner].
  - The arbiter never inspects addresses. A requester may change addr every cycle, and the mux passes each change through.
- Release:
  - In BUSY with req_ce_i[owner]=0: last<=owner.
  - If another ce is pending, the arbiter hands off with no bubble: the search runs from owner+1, owner<=winner, state stays BUSY, hold_cnt<=0.
  - Otherwise state<=IDLE.
  - mem_ce_o is 0 during the release cycle.
- Hold check:
  - In BUSY with the owner's ce high: hold_cnt increments and saturates at all-ones.
  - If MAX_HOLD!=0 and hold_cnt reaches MAX_HOLD: hold_err_o<=1, held until reset. This is a flag only; the grant is not revoked.
- Non-owner requesters:
  - See ready=0 and must keep ce high while waiting.
  - A requester that drops ce before being granted is simply skipped.
- Simultaneous requests from IDLE resolve purely by rotation after `last`. Immediately after reset the first winner is the lowest index with ce set.
- mem_ready_i is ignored in IDLE and during the release cycle.

Test Plan:
- Single requester: req 1 raises ce at cycle 0 with addr 0x100, then 0x104 on the following ready.
  - mem_ce_o=1 from cycle 1; grant_o=0010.
  - req_ready_o[1] mirrors mem_ready_i; the addresses pass through unchanged.
- All four requesters raise ce together after reset, each holding for 3 cycles.
  - Grant order 0,1,2,3 with zero-bubble handoffs; each grant_o bit is high for exactly 3 cycles plus 1 release cycle.
- Lock check: req 0 is mid-burst while req 2 asserts ce.
  - No access for req 2 appears on mem_* until req 0 drops ce.
  - req_ready_o[2] stays 0 throughout.
- Fairness: req 0 re-asserts ce immediately after each release while req 3 waits.
  - req 3 is granted before req 0's second grant.
- Reset mid-burst: rst is asserted while req 1 owns the port.
  - mem_ce_o=0 in the same cycle.
  - After reset, state is IDLE and hold_err_o=0.
- Hold timeout: MAX_HOLD=8, req 2 holds ce for 20 cycles.
  - hold_err_o rises after 8 held cycles and stays 1.
  - The grant is not revoked until req 2 drops ce.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one word-wide memory port among NUM_REQ requesters.
// A grant stays locked to its owner for as long as the owner holds ce.
module mem_port_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_HOLD = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_ce_i,
  input  logic [NUM_REQ-1:0]        req_we_i,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
  input  logic [NUM_REQ*4-1:0]      req_width_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  output logic [DATA_W-1:0]         req_data_o,
  output logic                      mem_ce_o,
  output logic                      mem_we_o,
  output logic [ADDR_W-1:0]         mem_addr_o,
  output logic [3:0]                mem_width_o,
  output logic [DATA_W-1:0]         mem_data_o,
  input  logic [DATA_W-1:0]         mem_data_i,
  input  logic                      mem_ready_i,
  output logic [NUM_REQ-1:0]        grant_o,
  output logic                      hold_err_o
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (MAX_HOLD < 65535) ? 16 : 32;
  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD);
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic             hold_err_q, hold_err_d;

  logic [IDX_W-1:0] search_base;
  logic [IDX_W-1:0] cand;
  logic [IDX_W-1:0] win_idx;
  logic             win_found;
  logic             owner_ce;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    r = (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    return r;
  endfunction

  assign owner_ce = req_ce_i[owner_q];

  // Rotating search: starts after the last owner from IDLE, after the current owner on release
  always_comb begin
    search_base = (state_q == S_BUSY) ? owner_q : last_q;
    win_found   = 1'b0;
    win_idx     = '0;
    cand        = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(search_base) + k) % NUM_REQ);
      if (!win_found && req_ce_i[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    hold_cnt_d = hold_cnt_q;
    hold_err_d = hold_err_q;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          state_d    = S_BUSY;
          owner_d    = win_idx;
          hold_cnt_d = '0;
        end
      end
      default: begin
        if (owner_ce) begin
          hold_cnt_d = sat_inc(hold_cnt_q);
          if (MAX_HOLD != 0 && hold_cnt_d >= HOLD_LIM) begin
            hold_err_d = 1'b1;
          end
        end else begin
          // Release cycle: hand off directly to a pending requester when there is one
          last_d = owner_q;
          if (win_found) begin
            owner_d    = win_idx;
            hold_cnt_d = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      owner_q    <= '0;
      last_q     <= LAST_RST;
      hold_cnt_q <= '0;
      hold_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      hold_cnt_q <= hold_cnt_d;
      hold_err_q <= hold_err_d;
    end
  end

  // Port mux is gated by rst so a reset mid-burst drops the memory port in the same cycle
  always_comb begin
    mem_ce_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_width_o = '0;
    mem_data_o  = '0;
    req_ready_o = '0;
    grant_o     = '0;
    if (!rst && state_q == S_BUSY) begin
      grant_o[owner_q] = 1'b1;
      mem_addr_o       = req_addr_i[int'(owner_q)*ADDR_W +: ADDR_W];
      mem_width_o      = req_width_i[int'(owner_q)*4 +: 4];
      mem_data_o       = req_data_i[int'(owner_q)*DATA_W +: DATA_W];
      if (owner_ce) begin
        mem_ce_o             = 1'b1;
        mem_we_o             = req_we_i[owner_q];
        req_ready_o[owner_q] = mem_ready_i;
      end
    end
  end

  assign req_data_o = mem_data_i;
  assign hold_err_o = hold_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter with a cycle-level reference model.
module tb_mem_port_arbiter;
  localparam int N    = 4;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXH = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_ce, req_we;
  logic [N*AW-1:0] req_addr;
  logic [N*4-1:0]  req_width;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready_o;
  logic [DW-1:0]   req_data_o;
  logic            mem_ce_o, mem_we_o;
  logic [AW-1:0]   mem_addr_o;
  logic [3:0]      mem_width_o;
  logic [DW-1:0]   mem_data_o;
  logic [DW-1:0]   mem_data_i;
  logic            mem_ready_i;
  logic [N-1:0]    grant_o;
  logic            hold_err_o;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model state
  bit m_busy;
  int m_own, m_last, m_held;
  bit m_err;

  mem_port_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MAX_HOLD(MAXH)) dut (
    .clk(clk), .rst(rst),
    .req_ce_i(req_ce), .req_we_i(req_we), .req_addr_i(req_addr),
    .req_width_i(req_width), .req_data_i(req_data),
    .req_ready_o(req_ready_o), .req_data_o(req_data_o),
    .mem_ce_o(mem_ce_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_width_o(mem_width_o), .mem_data_o(mem_data_o),
    .mem_data_i(mem_data_i), .mem_ready_i(mem_ready_i),
    .grant_o(grant_o), .hold_err_o(hold_err_o)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int pick(input int from);
    for (int k = 1; k <= N; k++) begin
      if (req_ce[(from + k) % N]) return (from + k) % N;
    end
    return -1;
  endfunction

  task automatic update_model();
    int w;
    if (rst) begin
      m_busy = 0; m_own = 0; m_last = N - 1; m_held = 0; m_err = 0;
    end else if (!m_busy) begin
      w = pick(m_last);
      if (w >= 0) begin m_busy = 1; m_own = w; m_held = 0; end
    end else if (req_ce[m_own]) begin
      m_held++;
      if (MAXH != 0 && m_held >= MAXH) m_err = 1;
    end else begin
      m_last = m_own;
      w = pick(m_own);
      if (w >= 0) begin m_own = w; m_held = 0; end
      else m_busy = 0;
    end
  endtask

  task automatic check_all();
    logic [N-1:0] e_rdy;
    chk("req_data", 64'(req_data_o), 64'(mem_data_i));
    chk("hold_err", 64'(hold_err_o), 64'(m_err));
    if (rst) begin
      chk("rst_ce", 64'(mem_ce_o), 64'(0));
      chk("rst_we", 64'(mem_we_o), 64'(0));
      chk("rst_addr", 64'(mem_addr_o), 64'(0));
      chk("rst_width", 64'(mem_width_o), 64'(0));
      chk("rst_wdata", 64'(mem_data_o), 64'(0));
      chk("rst_ready", 64'(req_ready_o), 64'(0));
      chk("rst_grant", 64'(grant_o), 64'(0));
    end else if (!m_busy) begin
      chk("idle_ce", 64'(mem_ce_o), 64'(0));
      chk("idle_we", 64'(mem_we_o), 64'(0));
      chk("idle_ready", 64'(req_ready_o), 64'(0));
      chk("idle_grant", 64'(grant_o), 64'(0));
    end else begin
      chk("grant", 64'(grant_o), 64'(1) << m_own);
      if (req_ce[m_own]) begin
        e_rdy = '0;
        e_rdy[m_own] = mem_ready_i;
        chk("ce", 64'(mem_ce_o), 64'(1));
        chk("we", 64'(mem_we_o), 64'(req_we[m_own]));
        chk("addr", 64'(mem_addr_o), 64'(req_addr[m_own*AW +: AW]));
        chk("width", 64'(mem_width_o), 64'(req_width[m_own*4 +: 4]));
        chk("wdata", 64'(mem_data_o), 64'(req_data[m_own*DW +: DW]));
        chk("ready", 64'(req_ready_o), 64'(e_rdy));
      end else begin
        chk("rel_ce", 64'(mem_ce_o), 64'(0));
        chk("rel_we", 64'(mem_we_o), 64'(0));
        chk("rel_ready", 64'(req_ready_o), 64'(0));
      end
    end
  endtask

  task automatic settle();
    #1;
    check_all();
  endtask

  task automatic advance();
    @(posedge clk);
    update_model();
    @(negedge clk);
  endtask

  task automatic tick();
    settle();
    advance();
  endtask

  task automatic randomize_fields();
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW]  = $urandom;
      req_width[i*4 +: 4]   = 4'($urandom);
      req_data[i*DW +: DW]  = $urandom;
    end
    req_we      = N'($urandom);
    mem_data_i  = $urandom;
    mem_ready_i = 1'($urandom);
  endtask

  task automatic do_reset();
    req_ce = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Held cycles per requester, for directed phases
  int h[N];
  int gcnt[N];
  int first[N];
  int own_was;

  task automatic count_held();
    own_was = (!rst && m_busy && req_ce[m_own]) ? m_own : -1;
    advance();
    if (own_was >= 0) h[own_was]++;
  endtask

  initial begin
    logic [N-1:0] seq[$];
    logic [N-1:0] prev_g;
    bit dropped, saw2;
    int remain[N], gap[N];
    bit act[N];

    rst = 1'b1; req_ce = '0; req_we = '0; req_addr = '0; req_width = '0; req_data = '0;
    mem_data_i = '0; mem_ready_i = 1'b0;
    m_busy = 0; m_own = 0; m_last = N - 1; m_held = 0; m_err = 0;
    @(negedge clk);
    tick(); tick();
    rst = 1'b0;
    settle();
    chk("post_rst_grant", 64'(grant_o), 64'(0));
    chk("post_rst_err", 64'(hold_err_o), 64'(0));
    advance();

    // Single requester
    req_ce = 4'b0010; req_addr[1*AW +: AW] = 32'h100; mem_ready_i = 1'b0;
    settle(); chk("t1_c0_ce", 64'(mem_ce_o), 64'(0)); advance();
    mem_ready_i = 1'b1;
    settle();
    chk("t1_ce", 64'(mem_ce_o), 64'(1));
    chk("t1_grant", 64'(grant_o), 64'(4'b0010));
    chk("t1_addr0", 64'(mem_addr_o), 64'(32'h100));
    chk("t1_rdy", 64'(req_ready_o), 64'(4'b0010));
    advance();
    req_addr[1*AW +: AW] = 32'h104; mem_ready_i = 1'b0;
    settle();
    chk("t1_addr1", 64'(mem_addr_o), 64'(32'h104));
    chk("t1_nrdy", 64'(req_ready_o), 64'(0));
    advance();
    mem_ready_i = 1'b1;
    tick();
    req_ce = '0;
    settle(); chk("t1_rel_ce", 64'(mem_ce_o), 64'(0)); advance();
    settle(); chk("t1_idle", 64'(grant_o), 64'(0)); advance();

    // All four together, 3 held cycles each
    do_reset();
    for (int i = 0; i < N; i++) begin h[i] = 0; gcnt[i] = 0; first[i] = -1; end
    req_ce = '1;
    for (int c = 0; c < 20; c++) begin
      for (int i = 0; i < N; i++) if (h[i] >= 3) req_ce[i] = 1'b0;
      settle();
      for (int i = 0; i < N; i++) if (grant_o[i]) begin
        gcnt[i]++;
        if (first[i] < 0) first[i] = c;
      end
      count_held();
    end
    chk("all4_first0", 64'(first[0]), 64'(1));
    for (int i = 0; i < N; i++) chk("all4_gcnt", 64'(gcnt[i]), 64'(4));
    for (int i = 1; i < N; i++) chk("all4_nobubble", 64'(first[i]), 64'(first[i-1] + 4));

    // Lock: req 2 waits while req 0 holds its burst
    do_reset();
    for (int i = 0; i < N; i++) h[i] = 0;
    randomize_fields();
    req_addr[0 +: AW] = 32'h200; req_addr[2*AW +: AW] = 32'hDEAD0000; mem_ready_i = 1'b1;
    req_ce = 4'b0001; saw2 = 0;
    for (int c = 0; c < 12; c++) begin
      if (h[0] >= 2) req_ce[2] = 1'b1;
      if (h[0] >= 6) req_ce[0] = 1'b0;
      settle();
      if (m_busy && m_own == 0) begin
        chk("lock_rdy2", 64'(req_ready_o[2]), 64'(0));
        chk("lock_grant", 64'(grant_o), 64'(4'b0001));
        if (req_ce[0]) chk("lock_addr", 64'(mem_addr_o), 64'(32'h200));
      end
      if (grant_o == 4'b0100) saw2 = 1;
      count_held();
    end
    chk("lock_handoff", 64'(saw2), 64'(1));

    // Fairness: req 0 re-requests immediately, req 3 must go first
    do_reset();
    for (int i = 0; i < N; i++) h[i] = 0;
    req_ce = 4'b0001; dropped = 0; prev_g = '0; seq.delete();
    for (int c = 0; c < 14; c++) begin
      if (c == 1) req_ce[3] = 1'b1;
      if (h[3] >= 2) req_ce[3] = 1'b0;
      if (dropped) req_ce[0] = 1'b1;
      if (h[0] == 3 && !dropped) begin req_ce[0] = 1'b0; dropped = 1; end
      settle();
      if (grant_o != prev_g && grant_o != '0) seq.push_back(grant_o);
      prev_g = grant_o;
      count_held();
    end
    while (seq.size() < 3) seq.push_back('0);
    chk("fair_g0", 64'(seq[0]), 64'(4'b0001));
    chk("fair_g1", 64'(seq[1]), 64'(4'b1000));
    chk("fair_g2", 64'(seq[2]), 64'(4'b0001));

    // Reset in mid-burst
    do_reset();
    req_ce = 4'b0010;
    tick(); tick();
    rst = 1'b1;
    settle();
    chk("rstmid_ce", 64'(mem_ce_o), 64'(0));
    chk("rstmid_grant", 64'(grant_o), 64'(0));
    advance();
    rst = 1'b0; req_ce = '0;
    settle();
    chk("rstmid_idle", 64'(grant_o), 64'(0));
    chk("rstmid_err", 64'(hold_err_o), 64'(0));
    advance();

    // Hold timeout: req 2 holds 20 cycles
    do_reset();
    for (int i = 0; i < N; i++) h[i] = 0;
    req_ce = 4'b0100;
    for (int c = 0; c < 23; c++) begin
      if (h[2] >= 20) req_ce[2] = 1'b0;
      settle();
      if (c >= 1 && c <= 21) chk("hold_grant", 64'(grant_o), 64'(4'b0100));
      chk("hold_err_t", 64'(hold_err_o), 64'(h[2] >= MAXH));
      count_held();
    end
    settle(); chk("hold_sticky", 64'(hold_err_o), 64'(1)); advance();
    do_reset();
    settle(); chk("hold_clr", 64'(hold_err_o), 64'(0)); advance();

    // Randomized traffic
    for (int i = 0; i < N; i++) begin act[i] = 0; gap[i] = 0; remain[i] = 0; end
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      randomize_fields();
      for (int i = 0; i < N; i++) req_ce[i] = act[i];
      own_was = (!rst && m_busy && req_ce[m_own]) ? m_own : -1;
      tick();
      for (int i = 0; i < N; i++) begin
        if (act[i]) begin
          if (own_was == i) begin
            remain[i]--;
            if (remain[i] <= 0) begin act[i] = 0; gap[i] = $urandom_range(0, 3); end
          end else if (!(m_busy && m_own == i) && $urandom_range(0, 31) == 0) begin
            act[i] = 0; gap[i] = $urandom_range(0, 3);
          end
        end else if (gap[i] > 0) begin
          gap[i]--;
        end else if ($urandom_range(0, 1) == 0) begin
          act[i] = 1; remain[i] = $urandom_range(1, 12);
        end
      end
    end
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
